// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared types and constants for the control unit
//
// Purpose: state encoding, instruction classes, MIPS opcode/funct values,
//          ALU operation codes and small helpers used by control_unit and
//          cu_decode.
// Ports:   none (package).
package cu_pkg;

    // State code is exported on ramAddress, so the numbering is fixed.
    typedef enum logic [3:0] {
        RESET    = 4'd0,
        FETCH0   = 4'd1,
        FETCH1   = 4'd2,
        FETCH2   = 4'd3,
        DECODE   = 4'd4,
        ALU_R    = 4'd5,
        ALU_I    = 4'd6,
        MEM_ADDR = 4'd7,
        MEM_RD   = 4'd8,
        MEM_WR   = 4'd9,
        BRANCH   = 4'd10,
        INT      = 4'd11,
        TRAP     = 4'd12
    } cuState_t;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_ILLEGAL
    } instrClass_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_NOR   = 4'b0101;
    localparam logic [3:0] ALU_SLT   = 4'b0110;
    localparam logic [3:0] ALU_SLL   = 4'b0111;
    localparam logic [3:0] ALU_SRL   = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    // lw has opcode[1:0]=11 but the RAM encodes a word as 10.
    function automatic logic [1:0] memSize(input logic [5:0] opcode);
        return (opcode[1:0] == 2'b11) ? 2'b10 : opcode[1:0];
    endfunction

    // flags = {Z,N,C,V} from RS-RT; blez/bgtz compare RS against R0.
    function automatic logic branchTaken(input logic [1:0] cond, input logic [3:0] flags);
        logic lessThan;
        lessThan = flags[2] ^ flags[0];
        case (cond)
            2'b00:   return flags[3];
            2'b01:   return ~flags[3];
            2'b10:   return flags[3] | lessThan;
            default: return ~flags[3] & ~lessThan;
        endcase
    endfunction

endpackage

// File: rtl/cu_decode.sv
// rtl/cu_decode.sv - combinational opcode/funct classifier and ALU op select
//
// Purpose: maps the instruction opcode and funct fields to an instruction
//          class plus the ALU controls the execute states need.
// Ports:   opcode, funct      in  instruction fields
//          instrClass         out R / I / load / store / branch / illegal
//          aluOp, aluSigned   out ALU operation and signedness
//          zeroExt            out immediate is zero-extended (logical imm ops)
//          regWrite           out R-type funct writes the register file
//          mulDiv             out R-type funct loads HI/LO
module cu_decode
    import cu_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    output instrClass_t instrClass,
    output logic [3:0]  aluOp,
    output logic        aluSigned,
    output logic        zeroExt,
    output logic        regWrite,
    output logic        mulDiv
);

    always_comb begin
        instrClass = CLS_ILLEGAL;
        aluOp      = ALU_ADD;
        aluSigned  = 1'b0;
        zeroExt    = 1'b0;
        regWrite   = 1'b0;
        mulDiv     = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                instrClass = CLS_R;
                regWrite   = 1'b1;
                case (funct)
                    FN_ADD:  begin aluOp = ALU_ADD; aluSigned = 1'b1; end
                    FN_SUB:  begin aluOp = ALU_SUB; aluSigned = 1'b1; end
                    FN_AND:  aluOp = ALU_AND;
                    FN_OR:   aluOp = ALU_OR;
                    FN_XOR:  aluOp = ALU_XOR;
                    FN_NOR:  aluOp = ALU_NOR;
                    FN_SLT:  begin aluOp = ALU_SLT; aluSigned = 1'b1; end
                    FN_SLL:  aluOp = ALU_SLL;
                    FN_SRL:  aluOp = ALU_SRL;
                    FN_SRA:  aluOp = ALU_SRA;
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                        mulDiv    = 1'b1;
                        regWrite  = 1'b0;
                        aluSigned = ~funct[0];
                    end
                    // Unknown funct: execute as a no-op, nothing written.
                    default: regWrite = 1'b0;
                endcase
            end
            OP_ADDI: begin instrClass = CLS_I; aluOp = ALU_ADD; aluSigned = 1'b1; end
            OP_SLTI: begin instrClass = CLS_I; aluOp = ALU_SLT; aluSigned = 1'b1; end
            OP_ANDI: begin instrClass = CLS_I; aluOp = ALU_AND; zeroExt = 1'b1; end
            OP_ORI:  begin instrClass = CLS_I; aluOp = ALU_OR;  zeroExt = 1'b1; end
            OP_XORI: begin instrClass = CLS_I; aluOp = ALU_XOR; zeroExt = 1'b1; end
            OP_LB, OP_LH, OP_LW: instrClass = CLS_LOAD;
            OP_SB, OP_SH, OP_SW: instrClass = CLS_STORE;
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                instrClass = CLS_BRANCH;
                aluOp      = ALU_SUB;
                aluSigned  = 1'b1;
            end
            default: instrClass = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle MIPS-style control FSM
//
// Purpose: Moore-style sequencer for fetch/decode/execute with RAM handshake
//          (ramMFA/ramMFC), branch resolution from ALU flags and trap vectoring.
//          Define CU_INTERRUPT_EN to let FETCH0 divert to INT on an interrupt.
// Ports:   Clk, reset (async, active-low), instruction, aluCarryFlags {Z,N,C,V},
//          ramMFC, hardwareInterrupt, maskableInterrupt      in
//          cmpsignal, trapMux, clearPC, signExtend, regFileRW, regFileRS/RT/RD,
//          aluSign, aluOperation, ramDataSize, ramMFA, ramRW, ramAddress,
//          pcEnable, irEnable, marEnable, mdrEnable,
//          muxSignals, muxSignals2, muxSignals3                out
module control_unit
    import cu_pkg::*;
(
    input  logic        Clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic [3:0]  aluCarryFlags,
    input  logic        ramMFC,
    input  logic        hardwareInterrupt,
    input  logic        maskableInterrupt,
    output logic [2:0]  cmpsignal,
    output logic        trapMux,
    output logic        clearPC,
    output logic        signExtend,
    output logic        regFileRW,
    output logic [4:0]  regFileRS,
    output logic [4:0]  regFileRT,
    output logic [4:0]  regFileRD,
    output logic [1:0]  aluSign,
    output logic [3:0]  aluOperation,
    output logic [1:0]  ramDataSize,
    output logic        ramMFA,
    output logic        ramRW,
    output logic [8:0]  ramAddress,
    output logic        pcEnable,
    output logic        irEnable,
    output logic        marEnable,
    output logic        mdrEnable,
    output logic [1:0]  muxSignals,
    output logic        muxSignals2,
    output logic [1:0]  muxSignals3
);

    cuState_t    state, nextState;
    instrClass_t instrClass;
    logic [3:0]  aluOp;
    logic        aluSigned, zeroExt, regWrite, mulDiv;
    logic [5:0]  opcode;

    assign opcode = instruction[31:26];

    cu_decode decodeInst (
        .opcode     (opcode),
        .funct      (instruction[5:0]),
        .instrClass (instrClass),
        .aluOp      (aluOp),
        .aluSigned  (aluSigned),
        .zeroExt    (zeroExt),
        .regWrite   (regWrite),
        .mulDiv     (mulDiv)
    );

    // I-type instructions put their destination (rt) on the RD select.
    assign regFileRS  = instruction[25:21];
    assign regFileRT  = instruction[20:16];
    assign regFileRD  = (opcode == OP_RTYPE) ? instruction[15:11] : instruction[20:16];
    assign ramAddress = {5'b0, state};

    // shamt is consumed by the datapath directly; carry plays no part in branches.
    logic unusedBits;
`ifdef CU_INTERRUPT_EN
    assign unusedBits = ^{instruction[10:6], aluCarryFlags[1]};
`else
    assign unusedBits = ^{instruction[10:6], aluCarryFlags[1], hardwareInterrupt, maskableInterrupt};
`endif

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) state <= RESET;
        else        state <= nextState;
    end

    always_comb begin
        nextState    = state;
        cmpsignal    = 3'b000;
        trapMux      = 1'b0;
        clearPC      = 1'b0;
        signExtend   = 1'b0;
        regFileRW    = 1'b0;
        aluSign      = 2'b00;
        aluOperation = ALU_ADD;
        ramDataSize  = 2'b00;
        ramMFA       = 1'b0;
        ramRW        = 1'b0;
        pcEnable     = 1'b0;
        irEnable     = 1'b0;
        marEnable    = 1'b0;
        mdrEnable    = 1'b0;
        muxSignals   = 2'b00;
        muxSignals2  = 1'b0;
        muxSignals3  = 2'b00;
        case (state)
            RESET: begin
                clearPC   = 1'b1;
                nextState = FETCH0;
            end
            FETCH0: begin
                // MAR <- PC and PC <- PC+4 through the ALU in the same cycle.
                marEnable  = 1'b1;
                muxSignals = 2'b10;
                pcEnable   = 1'b1;
                nextState  = FETCH1;
`ifdef CU_INTERRUPT_EN
                // Both sources share the one vector; hardware is tested first.
                if (hardwareInterrupt)      nextState = INT;
                else if (maskableInterrupt) nextState = INT;
`endif
            end
            FETCH1: begin
                ramMFA      = 1'b1;
                ramRW       = 1'b1;
                ramDataSize = 2'b10;
                if (ramMFC) nextState = FETCH2;
            end
            FETCH2: begin
                irEnable  = 1'b1;
                nextState = DECODE;
            end
            DECODE: begin
                case (instrClass)
                    CLS_R:                 nextState = ALU_R;
                    CLS_I:                 nextState = ALU_I;
                    CLS_LOAD, CLS_STORE:   nextState = MEM_ADDR;
                    CLS_BRANCH:            nextState = BRANCH;
                    default:               nextState = TRAP;
                endcase
            end
            ALU_R: begin
                aluOperation = aluOp;
                aluSign      = {1'b0, aluSigned};
                regFileRW    = regWrite;
                muxSignals3  = mulDiv ? 2'b11 : 2'b00;
                nextState    = FETCH0;
            end
            ALU_I: begin
                aluOperation = aluOp;
                aluSign      = {1'b0, aluSigned};
                muxSignals   = 2'b01;
                regFileRW    = 1'b1;
                signExtend   = ~zeroExt;
                nextState    = FETCH0;
            end
            MEM_ADDR: begin
                muxSignals = 2'b01;
                signExtend = 1'b1;
                marEnable  = 1'b1;
                nextState  = (instrClass == CLS_LOAD) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                ramMFA      = 1'b1;
                ramRW       = 1'b1;
                ramDataSize = memSize(opcode);
                muxSignals2 = 1'b1;
                // MDR and the register file capture only once the data is valid.
                mdrEnable   = ramMFC;
                regFileRW   = ramMFC;
                if (ramMFC) nextState = FETCH0;
            end
            MEM_WR: begin
                ramMFA      = 1'b1;
                ramDataSize = memSize(opcode);
                if (ramMFC) nextState = FETCH0;
            end
            BRANCH: begin
                aluOperation = ALU_SUB;
                aluSign      = 2'b01;
                cmpsignal    = {1'b0, opcode[1:0]};
                pcEnable     = branchTaken(opcode[1:0], aluCarryFlags);
                nextState    = FETCH0;
            end
            INT, TRAP: begin
                trapMux   = 1'b1;
                pcEnable  = 1'b1;
                nextState = FETCH0;
            end
            default: nextState = RESET;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed self-checking bench for control_unit
module tb_control_unit;

    logic        Clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic [3:0]  aluCarryFlags;
    logic        ramMFC, hardwareInterrupt, maskableInterrupt;
    logic [2:0]  cmpsignal;
    logic        trapMux, clearPC, signExtend, regFileRW;
    logic [4:0]  regFileRS, regFileRT, regFileRD;
    logic [1:0]  aluSign;
    logic [3:0]  aluOperation;
    logic [1:0]  ramDataSize;
    logic        ramMFA, ramRW;
    logic [8:0]  ramAddress;
    logic        pcEnable, irEnable, marEnable, mdrEnable;
    logic [1:0]  muxSignals;
    logic        muxSignals2;
    logic [1:0]  muxSignals3;

    int checks = 0;
    int errors = 0;

    control_unit dut (
        .Clk               (Clk),
        .reset             (reset),
        .instruction       (instruction),
        .aluCarryFlags     (aluCarryFlags),
        .ramMFC            (ramMFC),
        .hardwareInterrupt (hardwareInterrupt),
        .maskableInterrupt (maskableInterrupt),
        .cmpsignal         (cmpsignal),
        .trapMux           (trapMux),
        .clearPC           (clearPC),
        .signExtend        (signExtend),
        .regFileRW         (regFileRW),
        .regFileRS         (regFileRS),
        .regFileRT         (regFileRT),
        .regFileRD         (regFileRD),
        .aluSign           (aluSign),
        .aluOperation      (aluOperation),
        .ramDataSize       (ramDataSize),
        .ramMFA            (ramMFA),
        .ramRW             (ramRW),
        .ramAddress        (ramAddress),
        .pcEnable          (pcEnable),
        .irEnable          (irEnable),
        .marEnable         (marEnable),
        .mdrEnable         (mdrEnable),
        .muxSignals        (muxSignals),
        .muxSignals2       (muxSignals2),
        .muxSignals3       (muxSignals3)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // From RESET or any execute state: walk FETCH0..DECODE with ramMFC=1.
    task automatic fetchDecode(input logic [31:0] ins);
        instruction = ins;
        ramMFC = 1'b1;
        tick();
        check("fetch0 state", ramAddress, 9'd1);
        check("fetch0 pcEnable", pcEnable, 1'b1);
        check("fetch0 marEnable", marEnable, 1'b1);
        check("fetch0 muxSignals", muxSignals, 2'b10);
        tick();
        check("fetch1 state", ramAddress, 9'd2);
        check("fetch1 ramMFA", ramMFA, 1'b1);
        check("fetch1 ramDataSize", ramDataSize, 2'b10);
        tick();
        check("fetch2 irEnable", irEnable, 1'b1);
        tick();
        check("decode state", ramAddress, 9'd4);
    endtask

    initial begin
        reset = 1'b0;
        instruction = 32'h0022_1820;
        aluCarryFlags = 4'b0000;
        ramMFC = 1'b1;
        hardwareInterrupt = 1'b0;
        maskableInterrupt = 1'b0;
        repeat (2) tick();
        check("reset state", ramAddress, 9'd0);
        check("reset clearPC", clearPC, 1'b1);
        check("reset pcEnable", pcEnable, 1'b0);
        check("reset ramMFA", ramMFA, 1'b0);
        check("reset regFileRW", regFileRW, 1'b0);
        @(negedge Clk) reset = 1'b1;

        // add $3,$1,$2 : ALU_R on the 5th edge after reset release
        fetchDecode(32'h0022_1820);
        tick();
        check("add state", ramAddress, 9'd5);
        check("add regFileRW", regFileRW, 1'b1);
        check("add aluOperation", aluOperation, 4'b0000);
        check("add muxSignals", muxSignals, 2'b00);
        check("add RS", regFileRS, 5'd1);
        check("add RT", regFileRT, 5'd2);
        check("add RD", regFileRD, 5'd3);

        // lb, then reset asynchronously while waiting in MEM_RD
        fetchDecode(32'h8200_0000);
        tick();
        check("lb memaddr state", ramAddress, 9'd7);
        check("lb memaddr marEnable", marEnable, 1'b1);
        check("lb memaddr signExtend", signExtend, 1'b1);
        check("lb memaddr muxSignals", muxSignals, 2'b01);
        ramMFC = 1'b0;
        tick();
        check("lb memrd state", ramAddress, 9'd8);
        check("lb ramMFA", ramMFA, 1'b1);
        check("lb ramRW", ramRW, 1'b1);
        check("lb ramDataSize", ramDataSize, 2'b00);
        check("lb muxSignals2", muxSignals2, 1'b1);
        check("lb mdrEnable before MFC", mdrEnable, 1'b0);
        check("lb RS", regFileRS, 5'd16);
        check("lb RD", regFileRD, 5'd0);
        tick();
        check("lb memrd hold", ramAddress, 9'd8);
        ramMFC = 1'b1;
        #1;
        check("lb mdrEnable on MFC", mdrEnable, 1'b1);
        check("lb regFileRW on MFC", regFileRW, 1'b1);
        ramMFC = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        check("async reset state", ramAddress, 9'd0);
        check("async reset clearPC", clearPC, 1'b1);
        check("async reset ramMFA", ramMFA, 1'b0);
        @(negedge Clk) reset = 1'b1;

        // Fetch stalls in FETCH1 while ramMFC stays low, then a sw
        instruction = 32'hAC00_0000;
        tick();
        check("stall fetch0", ramAddress, 9'd1);
        tick();
        repeat (12) tick();
        check("stall state", ramAddress, 9'd2);
        check("stall ramMFA", ramMFA, 1'b1);
        ramMFC = 1'b1;
        tick();
        check("stall released", ramAddress, 9'd3);
        tick();
        tick();
        check("sw memaddr state", ramAddress, 9'd7);
        tick();
        check("sw memwr state", ramAddress, 9'd9);
        check("sw ramRW", ramRW, 1'b0);
        check("sw ramDataSize", ramDataSize, 2'b10);
        check("sw ramMFA", ramMFA, 1'b1);
        check("sw regFileRW", regFileRW, 1'b0);

        // Illegal opcode 0x3F
        fetchDecode(32'hFC00_0000);
        tick();
        check("trap state", ramAddress, 9'd12);
        check("trap trapMux", trapMux, 1'b1);
        check("trap pcEnable", pcEnable, 1'b1);

        // beq: taken on Z, not taken without
        fetchDecode(32'h1022_0000);
        aluCarryFlags = 4'b1000;
        tick();
        check("beq state", ramAddress, 9'd10);
        check("beq cmpsignal", cmpsignal, 3'b000);
        check("beq aluOperation", aluOperation, 4'b0001);
        check("beq taken", pcEnable, 1'b1);
        aluCarryFlags = 4'b0000;
        #1;
        check("beq not taken", pcEnable, 1'b0);

        // bgtz: taken when positive, not when N set
        fetchDecode(32'h1C20_0000);
        tick();
        check("bgtz cmpsignal", cmpsignal, 3'b011);
        check("bgtz taken", pcEnable, 1'b1);
        aluCarryFlags = 4'b0100;
        #1;
        check("bgtz not taken", pcEnable, 1'b0);
        aluCarryFlags = 4'b0000;

        // ori $2,$1,5 : zero-extended immediate, dest on RD
        fetchDecode(32'h3422_0005);
        tick();
        check("ori state", ramAddress, 9'd6);
        check("ori signExtend", signExtend, 1'b0);
        check("ori muxSignals", muxSignals, 2'b01);
        check("ori regFileRW", regFileRW, 1'b1);
        check("ori aluOperation", aluOperation, 4'b0011);
        check("ori RD", regFileRD, 5'd2);

        // mult $1,$2 : HI/LO load, no register write
        fetchDecode(32'h0022_0018);
        tick();
        check("mult muxSignals3", muxSignals3, 2'b11);
        check("mult regFileRW", regFileRW, 1'b0);

        // Interrupt request during FETCH0
        hardwareInterrupt = 1'b1;
        ramMFC = 1'b1;
        tick();
        check("irq fetch0", ramAddress, 9'd1);
        tick();
`ifdef CU_INTERRUPT_EN
        check("irq int state", ramAddress, 9'd11);
        check("irq trapMux", trapMux, 1'b1);
`else
        check("irq ignored state", ramAddress, 9'd2);
        check("irq ignored trapMux", trapMux, 1'b0);
`endif
        hardwareInterrupt = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Clk  in  1  clock; all state changes on rising edge.
REQ-002 reset  in  1  asynchronous, active-low reset.
REQ-003 instruction  in  32  current IR contents, MIPS-style fields.
REQ-004 aluCarryFlags  in  4  {Z,N,C,V} from ALU.
REQ-005 ramMFC  in  1  memory-function-complete.
REQ-006 hardwareInterrupt, maskableInterrupt  in  1 each  interrupt requests.
REQ-007 cmpsignal  out  3  branch condition: 000 beq, 001 bne, 010 blez, 011 bgtz, 100 bltz, 101 bgez.
REQ-008 trapMux  out  1  selects interrupt vector into PC; clearPC out 1 zeroes PC.
REQ-009 signExtend  out  1  1=sign-extend imm16, 0=zero-extend.
REQ-010 regFileRW  out  1  1=register write; regFileRS/RT/RD out 5 each, register selects.
REQ-011 aluSign  out  2  00 unsigned, 01 signed; aluOperation out 4: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 nor, 0110 slt, 0111 sll, 1000 srl, 1001 sra, 1010 pass-B.
REQ-012 ramDataSize  out  2  00 byte, 01 half, 10 word; ramMFA out 1 start access; ramRW out 1 (1 read, 0 write).
REQ-013 ramAddress  out  9  control-store address = zero-extended current state code.
REQ-014 pcEnable, irEnable, marEnable, mdrEnable  out  1 each  register loads.
REQ-015 muxSignals  out  2  ALU-B: 00 RT, 01 imm, 10 constant 4, 11 MDR; muxSignals2 out 1 MDR source: 0 ALU, 1 RAM; muxSignals3 out 2 HI/LO load: 00 none, 01 LO, 10 HI, 11 both.

Function
REQ-016 Moore FSM; states: RESET(0), FETCH0, FETCH1, FETCH2, DECODE, ALU_R, ALU_I, MEM_ADDR, MEM_RD, MEM_WR, BRANCH, INT, TRAP.
REQ-017 RS=instruction[25:21], RT=[20:16], RD=[15:11] for R-type; I-type destination driven on RD = [20:16]; combinational from instruction.
REQ-018 RESET: clearPC=1, all other outputs 0; next FETCH0.
REQ-019 FETCH0: marEnable=1, muxSignals=10, aluOperation=add, pcEnable=1 (PC+4).
REQ-020 FETCH1: ramMFA=1, ramRW=1, ramDataSize=10; stays until ramMFC=1, then FETCH2.
REQ-021 FETCH2: irEnable=1; next DECODE.
REQ-022 DECODE: opcode 0 -> ALU_R; addi/andi/ori/xori/slti -> ALU_I; loads/stores -> MEM_ADDR; beq/bne/blez/bgtz -> BRANCH; else TRAP.
REQ-023 ALU_R: aluOperation from funct (0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor, 0x2A slt), regFileRW=1, muxSignals=00; mult/div set muxSignals3=11, regFileRW=0; next FETCH0.
REQ-024 ALU_I: muxSignals=01, regFileRW=1, signExtend=0 only for andi/ori/xori; next FETCH0.
REQ-025 MEM_ADDR: add, muxSignals=01, signExtend=1, marEnable=1; load -> MEM_RD, store -> MEM_WR.
REQ-026 MEM_RD/MEM_WR: ramMFA=1, ramRW per op, ramDataSize from opcode[1:0] (lb 00, lh 01, lw 10); hold until ramMFC; MEM_RD also mdrEnable=1, muxSignals2=1, regFileRW=1 on MFC cycle; next FETCH0.
REQ-027 BRANCH: aluOperation=sub, cmpsignal from opcode; pcEnable=1 only if condition true on aluCarryFlags; next FETCH0.
REQ-028 TRAP/INT: trapMux=1, pcEnable=1; next FETCH0.
REQ-029 ramMFC ignored outside FETCH1/MEM_RD/MEM_WR; no timeout.

Reset
REQ-030 reset low forces RESET asynchronously from any state, including mid-access; ramMFA drops immediately.

Configuration
REQ-031 CU_INTERRUPT_EN defined: in FETCH0, hardwareInterrupt=1 (or maskableInterrupt=1) -> INT instead of fetch, hardwareInterrupt priority; undefined: both inputs ignored, INT unreachable.

Structure
REQ-032 Package cu_pkg holds state enum, opcode/funct constants, ALU op codes.
REQ-033 One sub-module cu_decode: combinational opcode/funct -> class and ALU op.

Verification
REQ-034 instruction=0x00221820, ramMFC=1 after reset -> RS=1, RT=2, RD=3; regFileRW=1 in 5th cycle, aluOperation=0000.
REQ-035 instruction=0x82000000 (lb) -> RS=16, RD=0, ramDataSize=00, ramRW=1, muxSignals2=1 in MEM_RD.
REQ-036 ramMFC held 0 -> FSM stays FETCH1, ramMFA=1 indefinitely.
REQ-037 reset low in MEM_RD -> next sample ramAddress=0, clearPC=1.
REQ-038 opcode 0x3F -> TRAP, trapMux=1.
REQ-039 CU_INTERRUPT_EN, hardwareInterrupt=1 at FETCH0 -> INT, trapMux=1.
